// File: rtl/mem_wb_queue_pkg.sv
// Shared constants for the memory writeback queue.
//   - default geometry (queue length, data/register/level widths)
//   - access size encodings used by execute and by the lane aligner
//   - FSM state encodings of the bus sequencer
package mem_wb_queue_pkg;

  localparam int MEMQ_LEN  = 4;   // queue entries
  localparam int XLEN_W    = 32;  // data/address width
  localparam int RGBIT_W   = 5;   // register index width
  localparam int JCBUF_OFF = 2;   // speculation level width

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/mem_wb_queue_if.sv
// Data bus between the queue (master) and the memory agent (slave).
//   dmem_req/we/addr/wdata/be : request, held until dmem_gnt
//   dmem_gnt                  : request accepted this cycle
//   dmem_rvld/rdata           : load data return
interface mem_wb_queue_if #(
  parameter int XLEN = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_be;
  logic              dmem_gnt;
  logic              dmem_rvld;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvld, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvld, dmem_rdata
  );
endinterface

// File: rtl/mem_wb_queue_align.sv
// Combinational lane aligner for the head memory op.
//   size/is_unsigned/lane : access size, load zero-extend, addr[1:0]
//   wdata                 : LSB-justified store data
//   rdata                 : raw bus read word
//   be                    : byte enables (size mask shifted to lane)
//   wdata_rep             : store data replicated across all lanes
//   ld_data               : selected lane, sign/zero extended
module mem_wb_queue_align
  import mem_wb_queue_pkg::*;
#(
  parameter int XLEN = XLEN_W
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        lane,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic [XLEN-1:0]   ld_data
);
  localparam int BW = XLEN / 8;

  logic [BW-1:0]   mask_s;
  logic [XLEN-1:0] shifted_s;
  logic            ext_s;

  // Byte-enable mask, store replication and load extract/extend by access size.
  always_comb begin
    shifted_s = rdata >> {lane, 3'b000};
    mask_s    = BW'(4'hF);
    wdata_rep = {(BW/4){wdata[31:0]}};
    ext_s     = 1'b0;
    ld_data   = shifted_s;
    case (size)
      SZ_BYTE: begin
        mask_s    = BW'(4'h1);
        wdata_rep = {BW{wdata[7:0]}};
        ext_s     = ~is_unsigned & shifted_s[7];
        ld_data   = {{(XLEN-8){ext_s}}, shifted_s[7:0]};
      end
      SZ_HALF: begin
        mask_s    = BW'(4'h3);
        wdata_rep = {(BW/2){wdata[15:0]}};
        ext_s     = ~is_unsigned & shifted_s[15];
        ld_data   = {{(XLEN-16){ext_s}}, shifted_s[15:0]};
      end
      default: begin
        mask_s    = BW'(4'hF);
        wdata_rep = {(BW/4){wdata[31:0]}};
        ext_s     = 1'b0;
        ld_data   = shifted_s;
      end
    endcase
    be = mask_s << lane;
  end

endmodule

// File: rtl/mem_wb_queue.sv
// In-order load/store queue between execute and the register file.
// Ops wait until non-speculative (level 0), then go out on the data bus one
// at a time; each completion pulses mem_release, loads also return
// mem_sel/mem_data in that same cycle.
//   clk, rst (async, active low)
//   in_*            : op from execute, accepted on in_vld & in_rdy
//   level_decrease  : all levels -1 (saturating)
//   level_clear     : drop speculative entries (level != 0)
//   clear_pipeline  : drop every entry not yet on the bus
//   bus             : data bus master
//   mem_sel/mem_data/mem_release : load writeback and completion pulse
//   mem_count       : occupied entries including the in-flight one
module mem_wb_queue
  import mem_wb_queue_pkg::*;
#(
  parameter int DEPTH = MEMQ_LEN,
  parameter int XLEN  = XLEN_W,
  parameter int RGBIT = RGBIT_W,
  parameter int LVLW  = JCBUF_OFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic                   in_store,
  input  logic [1:0]             in_size,
  input  logic                   in_unsigned,
  input  logic [RGBIT-1:0]       in_rd_sel,
  input  logic [XLEN-1:0]        in_addr,
  input  logic [XLEN-1:0]        in_wdata,
  input  logic [LVLW-1:0]        in_level,
  input  logic                   level_decrease,
  input  logic                   level_clear,
  input  logic                   clear_pipeline,
  mem_wb_queue_if.master         bus,
  output logic [RGBIT-1:0]       mem_sel,
  output logic [XLEN-1:0]        mem_data,
  output logic                   mem_release,
  output logic [$clog2(DEPTH):0] mem_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Entry layout inside the flat queue vector, level at the LSB end.
  localparam int OFF_LVL = 0;
  localparam int OFF_WD  = OFF_LVL + LVLW;
  localparam int OFF_AD  = OFF_WD + XLEN;
  localparam int OFF_RD  = OFF_AD + XLEN;
  localparam int OFF_UNS = OFF_RD + RGBIT;
  localparam int OFF_SZ  = OFF_UNS + 1;
  localparam int OFF_ST  = OFF_SZ + 2;
  localparam int EW      = OFF_ST + 1;

  function automatic logic [LVLW-1:0] sub_level(input logic [LVLW-1:0] lvl);
    if (lvl == '0) begin
      sub_level = '0;
    end else begin
      sub_level = lvl - LVLW'(1);
    end
  endfunction

  // Slot 0 is always the oldest entry; drops and pops shift younger ones down.
  logic [DEPTH*EW-1:0] q_r;
  logic [DEPTH*EW-1:0] q_nxt_s;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       cnt_nxt_s;
  logic [1:0]          state_r;

  logic                req_r;
  logic                we_r;
  logic [XLEN-1:0]     addr_r;
  logic [XLEN-1:0]     wdata_r;
  logic [XLEN/8-1:0]   be_r;
  logic [RGBIT-1:0]    sel_r;
  logic [XLEN-1:0]     data_r;
  logic                release_r;

  logic [EW-1:0]       head_s;
  logic                head_store_s;
  logic [1:0]          head_size_s;
  logic                head_uns_s;
  logic [RGBIT-1:0]    head_rd_s;
  logic [XLEN-1:0]     head_addr_s;
  logic [XLEN-1:0]     head_wdata_s;
  logic [LVLW-1:0]     head_lvl_s;

  logic [XLEN/8-1:0]   al_be_s;
  logic [XLEN-1:0]     al_wdata_s;
  logic [XLEN-1:0]     al_ld_s;

  logic                in_rdy_s;
  logic                push_ok_s;
  logic [LVLW-1:0]     push_lvl_s;
  logic [EW-1:0]       push_ent_s;
  logic                pop_s;
  logic                start_s;

  assign head_s       = q_r[EW-1:0];
  assign head_store_s = head_s[OFF_ST];
  assign head_size_s  = head_s[OFF_SZ +: 2];
  assign head_uns_s   = head_s[OFF_UNS];
  assign head_rd_s    = head_s[OFF_RD +: RGBIT];
  assign head_addr_s  = head_s[OFF_AD +: XLEN];
  assign head_wdata_s = head_s[OFF_WD +: XLEN];
  assign head_lvl_s   = head_s[OFF_LVL +: LVLW];

  mem_wb_queue_align #(.XLEN(XLEN)) u_align (
    .size        (head_size_s),
    .is_unsigned (head_uns_s),
    .lane        (head_addr_s[1:0]),
    .wdata       (head_wdata_s),
    .rdata       (bus.dmem_rdata),
    .be          (al_be_s),
    .wdata_rep   (al_wdata_s),
    .ld_data     (al_ld_s)
  );

  // Full is decided on the registered count only; a same-cycle pop does not help.
  assign in_rdy_s   = (count_r != CW'(DEPTH));
  // A new op already sees this cycle's decrement, but is cleared on its issue level.
  assign push_lvl_s = level_decrease ? sub_level(in_level) : in_level;
  assign push_ok_s  = in_vld && in_rdy_s && !clear_pipeline &&
                      !(level_clear && (in_level != '0));
  assign push_ent_s = {in_store, in_size, in_unsigned, in_rd_sel, in_addr, in_wdata, push_lvl_s};

  assign pop_s   = ((state_r == ST_REQ) && bus.dmem_gnt && head_store_s) ||
                   ((state_r == ST_WAIT) && bus.dmem_rvld);
  assign start_s = (state_r == ST_IDLE) && (count_r != '0) &&
                   (head_lvl_s == '0) && !clear_pipeline;

  // Next queue image: pop, drop and age every entry, compact, then append the push.
  always_comb begin
    int            k;
    logic [EW-1:0] ent;
    logic          locked;
    logic          drop;
    logic          keep;
    q_nxt_s = '0;
    k       = 0;
    ent     = '0;
    locked  = 1'b0;
    drop    = 1'b0;
    keep    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent    = q_r[i*EW +: EW];
      // The head on the bus is level 0 and always completes normally.
      locked = (i == 0) && (state_r != ST_IDLE);
      drop   = clear_pipeline || (level_clear && (ent[OFF_LVL +: LVLW] != '0));
      keep   = (i < int'(count_r)) && !((i == 0) && pop_s) && (locked || !drop);
      if (level_decrease) begin
        ent[OFF_LVL +: LVLW] = sub_level(ent[OFF_LVL +: LVLW]);
      end else begin
        ent = ent;
      end
      if (keep) begin
        q_nxt_s[k*EW +: EW] = ent;
        k = k + 1;
      end else begin
        k = k;
      end
    end
    if (push_ok_s) begin
      q_nxt_s[k*EW +: EW] = push_ent_s;
      k = k + 1;
    end else begin
      k = k;
    end
    cnt_nxt_s = CW'(k);
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r     <= '0;
      count_r <= '0;
    end else begin
      q_r     <= q_nxt_s;
      count_r <= cnt_nxt_s;
    end
  end

  // Bus sequencer with registered bus fields and writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      be_r      <= '0;
      sel_r     <= '0;
      data_r    <= '0;
      release_r <= 1'b0;
    end else begin
      release_r <= 1'b0;
      sel_r     <= '0;
      data_r    <= '0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
            we_r    <= head_store_s;
            addr_r  <= {head_addr_s[XLEN-1:2], 2'b00};
            wdata_r <= al_wdata_s;
            be_r    <= al_be_s;
          end
        end
        ST_REQ: begin
          if (bus.dmem_gnt) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            be_r    <= '0;
            if (head_store_s) begin
              state_r   <= ST_IDLE;
              release_r <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.dmem_rvld) begin
            state_r   <= ST_IDLE;
            release_r <= 1'b1;
            sel_r     <= head_rd_s;
            data_r    <= al_ld_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy         = in_rdy_s;
  assign mem_count      = count_r;
  assign mem_sel        = sel_r;
  assign mem_data       = data_r;
  assign mem_release    = release_r;
  assign bus.dmem_req   = req_r;
  assign bus.dmem_we    = we_r;
  assign bus.dmem_addr  = addr_r;
  assign bus.dmem_wdata = wdata_r;
  assign bus.dmem_be    = be_r;

endmodule

// File: tb/tb_mem_wb_queue.sv
// Directed bench for mem_wb_queue: a table of single-op vectors plus
// hand-written sequences for full queue, speculation levels and flush.
module tb_mem_wb_queue;
  import mem_wb_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        in_store = 1'b0;
  logic [1:0]  in_size = 2'd0;
  logic        in_unsigned = 1'b0;
  logic [4:0]  in_rd_sel = 5'd0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [1:0]  in_level = 2'd0;
  logic        level_decrease = 1'b0;
  logic        level_clear = 1'b0;
  logic        clear_pipeline = 1'b0;
  logic [4:0]  mem_sel;
  logic [31:0] mem_data;
  logic        mem_release;
  logic [2:0]  mem_count;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_queue_if #(.XLEN(32)) bus ();

  mem_wb_queue #(.DEPTH(4), .XLEN(32), .RGBIT(5), .LVLW(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .in_store       (in_store),
    .in_size        (in_size),
    .in_unsigned    (in_unsigned),
    .in_rd_sel      (in_rd_sel),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_level       (in_level),
    .level_decrease (level_decrease),
    .level_clear    (level_clear),
    .clear_pipeline (clear_pipeline),
    .bus            (bus),
    .mem_sel        (mem_sel),
    .mem_data       (mem_data),
    .mem_release    (mem_release),
    .mem_count      (mem_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic st, input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] lvl);
    in_vld      = 1'b1;
    in_store    = st;
    in_size     = sz;
    in_unsigned = uns;
    in_rd_sel   = rd;
    in_addr     = addr;
    in_wdata    = wd;
    in_level    = lvl;
    step();
    in_vld      = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.dmem_req && n < 20) begin
      step();
      n++;
    end
    check({name, " req seen"}, 32'(bus.dmem_req), 32'd1);
  endtask

  task automatic grant_store(input string name, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    wait_req(name);
    check({name, " we"},    32'(bus.dmem_we), 32'd1);
    check({name, " addr"},  bus.dmem_addr, exp_addr);
    check({name, " be"},    32'(bus.dmem_be), 32'(exp_be));
    check({name, " wdata"}, bus.dmem_wdata, exp_wdata);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    check({name, " release"}, 32'(mem_release), 32'd1);
    check({name, " sel"},     32'(mem_sel), 32'd0);
    step();
    check({name, " release end"}, 32'(mem_release), 32'd0);
  endtask

  task automatic grant_load(input string name, input logic [31:0] exp_addr, input logic [31:0] rdata,
                            input logic [4:0] exp_sel, input logic [31:0] exp_data);
    wait_req(name);
    check({name, " we"},   32'(bus.dmem_we), 32'd0);
    check({name, " addr"}, bus.dmem_addr, exp_addr);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    check({name, " req drop"},     32'(bus.dmem_req), 32'd0);
    check({name, " early release"}, 32'(mem_release), 32'd0);
    step();
    bus.dmem_rvld  = 1'b1;
    bus.dmem_rdata = rdata;
    step();
    bus.dmem_rvld  = 1'b0;
    bus.dmem_rdata = 32'd0;
    check({name, " release"}, 32'(mem_release), 32'd1);
    check({name, " sel"},     32'(mem_sel), 32'(exp_sel));
    if (exp_sel != 5'd0) begin
      check({name, " data"}, mem_data, exp_data);
    end
    step();
    check({name, " release end"}, 32'(mem_release), 32'd0);
    check({name, " sel idle"},    32'(mem_sel), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dmem_gnt   = 1'b0;
    bus.dmem_rvld  = 1'b0;
    bus.dmem_rdata = 32'd0;

    //                 st    size     uns   rd     addr        wdata         rdata         exp_addr    be     exp_wdata     exp_data
    vecs[0] = '{1'b0, SZ_WORD, 1'b0, 5'd5,  32'h100, 32'h0,        32'h12345678, 32'h100, 4'hF, 32'h0,        32'h12345678};
    vecs[1] = '{1'b0, SZ_BYTE, 1'b0, 5'd6,  32'h103, 32'h0,        32'h80123456, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{1'b0, SZ_BYTE, 1'b1, 5'd6,  32'h103, 32'h0,        32'h80123456, 32'h100, 4'h8, 32'h0,        32'h00000080};
    vecs[3] = '{1'b0, SZ_HALF, 1'b0, 5'd8,  32'h102, 32'h0,        32'h80011234, 32'h100, 4'hC, 32'h0,        32'hFFFF8001};
    vecs[4] = '{1'b0, SZ_HALF, 1'b1, 5'd8,  32'h102, 32'h0,        32'h80011234, 32'h100, 4'hC, 32'h0,        32'h00008001};
    vecs[5] = '{1'b0, SZ_BYTE, 1'b0, 5'd31, 32'h101, 32'h0,        32'h00007F00, 32'h100, 4'h2, 32'h0,        32'h0000007F};
    vecs[6] = '{1'b0, SZ_WORD, 1'b0, 5'd0,  32'h104, 32'h0,        32'hDEADBEEF, 32'h104, 4'hF, 32'h0,        32'h0};
    vecs[7] = '{1'b1, SZ_HALF, 1'b0, 5'd0,  32'h102, 32'hFFFFABCD, 32'h0,        32'h100, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[8] = '{1'b1, SZ_BYTE, 1'b0, 5'd0,  32'h101, 32'h1234565A, 32'h0,        32'h100, 4'h2, 32'h5A5A5A5A, 32'h0};
    vecs[9] = '{1'b1, SZ_WORD, 1'b0, 5'd0,  32'h208, 32'h01020304, 32'h0,        32'h208, 4'hF, 32'h01020304, 32'h0};

    // Reset state
    step();
    step();
    check("rst req",     32'(bus.dmem_req), 32'd0);
    check("rst we",      32'(bus.dmem_we), 32'd0);
    check("rst addr",    bus.dmem_addr, 32'd0);
    check("rst wdata",   bus.dmem_wdata, 32'd0);
    check("rst be",      32'(bus.dmem_be), 32'd0);
    check("rst sel",     32'(mem_sel), 32'd0);
    check("rst data",    mem_data, 32'd0);
    check("rst release", 32'(mem_release), 32'd0);
    check("rst count",   32'(mem_count), 32'd0);
    check("rst in_rdy",  32'(in_rdy), 32'd1);
    rst = 1'b1;
    step();

    // Earliest issue: request one cycle after the op lands at the head
    push(1'b0, SZ_WORD, 1'b0, 5'd5, 32'h100, 32'h0, 2'd0);
    check("lat count", 32'(mem_count), 32'd1);
    check("lat req0",  32'(bus.dmem_req), 32'd0);
    step();
    check("lat req1",  32'(bus.dmem_req), 32'd1);
    grant_load("lat", 32'h100, 32'hA5A5_0001, 5'd5, 32'hA5A5_0001);

    // Single-op vectors
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].store, vecs[i].size, vecs[i].uns, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 2'd0);
      if (vecs[i].store) begin
        grant_store($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].exp_be, vecs[i].exp_wdata);
      end else begin
        grant_load($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].rdata, vecs[i].rd, vecs[i].exp_data);
      end
      check($sformatf("v%0d count", i), 32'(mem_count), 32'd0);
    end

    // Full queue with the bus stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      push(1'b1, SZ_WORD, 1'b0, 5'd0, 32'h10 + 32'(4 * i), 32'h100 + 32'(i), 2'd0);
    end
    check("full in_rdy", 32'(in_rdy), 32'd0);
    check("full count",  32'(mem_count), 32'd4);
    push(1'b1, SZ_WORD, 1'b0, 5'd0, 32'h50, 32'h999, 2'd0);
    check("full no push", 32'(mem_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      grant_store($sformatf("drain%0d", i), 32'h10 + 32'(4 * i), 4'hF, 32'h100 + 32'(i));
    end
    check("drain count",  32'(mem_count), 32'd0);
    check("drain in_rdy", 32'(in_rdy), 32'd1);

    // Speculative head stalls until its level drops to zero
    push(1'b0, SZ_WORD, 1'b0, 5'd7, 32'h40, 32'h0, 2'd1);
    repeat (3) begin
      step();
      check("lvl1 stall req", 32'(bus.dmem_req), 32'd0);
    end
    check("lvl1 count", 32'(mem_count), 32'd1);
    level_decrease = 1'b1;
    step();
    level_decrease = 1'b0;
    grant_load("lvldec", 32'h40, 32'h11223344, 5'd7, 32'h11223344);

    // Mispredict drops the speculative head: no bus op, no release
    push(1'b1, SZ_WORD, 1'b0, 5'd0, 32'h60, 32'h1, 2'd2);
    step();
    level_clear = 1'b1;
    step();
    level_clear = 1'b0;
    check("lclr count", 32'(mem_count), 32'd0);
    repeat (4) begin
      step();
      check("lclr req",     32'(bus.dmem_req), 32'd0);
      check("lclr release", 32'(mem_release), 32'd0);
    end

    // Clear with same-cycle decrease tests the pre-decrease level
    push(1'b1, SZ_WORD, 1'b0, 5'd0, 32'h64, 32'h2, 2'd1);
    level_clear    = 1'b1;
    level_decrease = 1'b1;
    step();
    level_clear    = 1'b0;
    level_decrease = 1'b0;
    check("clr+dec count", 32'(mem_count), 32'd0);

    // Speculative push during a clear is refused
    level_clear = 1'b1;
    push(1'b1, SZ_WORD, 1'b0, 5'd0, 32'h68, 32'h3, 2'd2);
    level_clear = 1'b0;
    check("clr push count", 32'(mem_count), 32'd0);

    // Push with same-cycle decrease stores level 0 and issues
    level_decrease = 1'b1;
    push(1'b1, SZ_WORD, 1'b0, 5'd0, 32'h80, 32'h5, 2'd1);
    level_decrease = 1'b0;
    grant_store("push dec", 32'h80, 4'hF, 32'h5);

    // Flush with a load in flight: it writes back, the queued ops vanish
    push(1'b0, SZ_WORD, 1'b0, 5'd9,  32'h200, 32'h0, 2'd0);
    push(1'b0, SZ_WORD, 1'b0, 5'd10, 32'h204, 32'h0, 2'd0);
    push(1'b1, SZ_WORD, 1'b0, 5'd0,  32'h208, 32'h7, 2'd0);
    wait_req("flush");
    check("flush addr", bus.dmem_addr, 32'h200);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    check("flush pre count", 32'(mem_count), 32'd3);
    clear_pipeline = 1'b1;
    step();
    clear_pipeline = 1'b0;
    check("flush count", 32'(mem_count), 32'd1);
    bus.dmem_rvld  = 1'b1;
    bus.dmem_rdata = 32'hCAFEF00D;
    step();
    bus.dmem_rvld  = 1'b0;
    bus.dmem_rdata = 32'd0;
    check("flush release", 32'(mem_release), 32'd1);
    check("flush sel",     32'(mem_sel), 32'd9);
    check("flush data",    mem_data, 32'hCAFEF00D);
    check("flush end count", 32'(mem_count), 32'd0);
    repeat (4) begin
      step();
      check("flush no req",     32'(bus.dmem_req), 32'd0);
      check("flush no release", 32'(mem_release), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
